fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 116 +++++++++++
 tb/tb_fifo_burst_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Pops a showahead FIFO in bursts of up to BURST_LEN words onto a valid/ready
// stream; partial bursts are forced by an idle timeout or a flush request.
module fifo_burst_reader #(
   parameter int DWIDTH    = 4,
   parameter int AWIDTH    = 7,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] fifo_q_i,
   input  logic              fifo_empty_i,
   input  logic [AWIDTH:0]   fifo_usedw_i,
   output logic              fifo_rdreq_o,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   output logic              last_o,
   input  logic              ready_i,
   input  logic              flush_i,
   output logic              busy_o
);

   localparam int RW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AWIDTH:0] BURST_LEN_U = (AWIDTH+1)'(BURST_LEN);
   localparam logic [RW-1:0]   BURST_LEN_R = RW'(BURST_LEN);
   localparam logic [TW-1:0]   TIMEOUT_T   = TW'(TIMEOUT);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state;
   logic [RW-1:0]   remaining;
   logic [TW-1:0]   tmo_cnt;
   logic            flush_pend;

   logic            out_free;
   logic            pop;
   logic            start;
   logic            chain;
   logic [AWIDTH:0] usedw_after;
   logic [RW-1:0]   start_len;
   logic [RW-1:0]   chain_len;

   // The final pop of a burst may re-arm a new burst on the same edge so a
   // sustained stream has no bubble; usedw_after is the fill level after that pop.
   always_comb begin
      out_free    = !valid_o || ready_i;
      pop         = !srst_i && (state == BURST) && !fifo_empty_i && out_free && (remaining != '0);
      start       = (fifo_usedw_i >= BURST_LEN_U) ||
                    (!fifo_empty_i && (flush_pend || (tmo_cnt == TIMEOUT_T)));
      usedw_after = fifo_usedw_i - (AWIDTH+1)'(1);
      chain       = (usedw_after >= BURST_LEN_U) || ((usedw_after != '0) && flush_pend);
      start_len   = (fifo_usedw_i < BURST_LEN_U) ? RW'(fifo_usedw_i) : BURST_LEN_R;
      chain_len   = (usedw_after < BURST_LEN_U) ? RW'(usedw_after) : BURST_LEN_R;
   end

   assign fifo_rdreq_o = pop;
   assign busy_o       = (state != IDLE) || valid_o;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state      <= IDLE;
         remaining  <= '0;
         tmo_cnt    <= '0;
         flush_pend <= 1'b0;
         data_o     <= '0;
         valid_o    <= 1'b0;
         last_o     <= 1'b0;
      end else begin
         if (flush_i) begin
            flush_pend <= 1'b1;
         end else if ((state == IDLE) && fifo_empty_i) begin
            flush_pend <= 1'b0;
         end

         if (pop) begin
            data_o  <= fifo_q_i;
            valid_o <= 1'b1;
            last_o  <= (remaining == RW'(1));
         end else if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= BURST;
                  remaining <= start_len;
                  tmo_cnt   <= '0;
               end else if (fifo_empty_i) begin
                  tmo_cnt <= '0;
               end else if ((fifo_usedw_i < BURST_LEN_U) && (tmo_cnt != TIMEOUT_T)) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            BURST: begin
               tmo_cnt <= '0;
               if (pop) begin
                  if (remaining == RW'(1)) begin
                     if (chain) begin
                        remaining <= chain_len;
                     end else begin
                        state     <= IDLE;
                        remaining <= '0;
                     end
                  end else begin
                     remaining <= remaining - RW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-backed showahead FIFO feeds the
// reader and every word accepted on the stream is logged for comparison.
module tb_fifo_burst_reader;

   localparam int DWIDTH    = 4;
   localparam int AWIDTH    = 7;
   localparam int BURST_LEN = 8;
   localparam int TIMEOUT   = 16;

   logic              clk_i = 1'b0;
   logic              srst_i;
   logic [DWIDTH-1:0] fifo_q_i;
   logic              fifo_empty_i;
   logic [AWIDTH:0]   fifo_usedw_i;
   logic              fifo_rdreq_o;
   logic [DWIDTH-1:0] data_o;
   logic              valid_o;
   logic              last_o;
   logic              ready_i;
   logic              flush_i;
   logic              busy_o;

   always #5 clk_i = ~clk_i;

   fifo_burst_reader #(
      .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .srst_i(srst_i), .fifo_q_i(fifo_q_i), .fifo_empty_i(fifo_empty_i),
      .fifo_usedw_i(fifo_usedw_i), .fifo_rdreq_o(fifo_rdreq_o), .data_o(data_o),
      .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .flush_i(flush_i), .busy_o(busy_o)
   );

   logic [DWIDTH-1:0] fifo_mem[$];
   logic [DWIDTH-1:0] got_data[$];
   logic              got_last[$];
   int                got_cyc[$];
   int tests = 0, fails = 0, cyc = 0, pops = 0, bad_pops = 0, stab_errs = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      fifo_empty_i = (fifo_mem.size() == 0);
      fifo_usedw_i = (AWIDTH+1)'(fifo_mem.size());
      fifo_q_i     = fifo_empty_i ? '0 : fifo_mem[0];
   endtask

   task automatic push(input logic [DWIDTH-1:0] v);
      fifo_mem.push_back(v);
      refresh();
   endtask

   task automatic clear_log();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   // One clock: capture the handshake at the edge, apply the pop 1 ns later,
   // and leave inputs/outputs settled 2 ns after the edge.
   task automatic step();
      logic did_pop, pre_valid, pre_ready, pre_last;
      logic [DWIDTH-1:0] pre_data;
      @(posedge clk_i);
      did_pop   = fifo_rdreq_o;
      pre_valid = valid_o;
      pre_ready = ready_i;
      pre_data  = data_o;
      pre_last  = last_o;
      if (did_pop && fifo_empty_i) bad_pops++;
      if (pre_valid && pre_ready) begin
         got_data.push_back(pre_data);
         got_last.push_back(pre_last);
         got_cyc.push_back(cyc);
      end
      #1;
      if (did_pop && fifo_mem.size() > 0) begin
         void'(fifo_mem.pop_front());
         pops++;
      end
      refresh();
      cyc++;
      #1;
      if (pre_valid && !pre_ready &&
          (valid_o !== 1'b1 || data_o !== pre_data || last_o !== pre_last)) stab_errs++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until(input int n, input int budget, input bit toggle, input string tag);
      int k;
      k = 0;
      while (got_data.size() < n && k < budget) begin
         if (toggle) ready_i = ~ready_i;
         step();
         k++;
      end
      check($sformatf("%s word count", tag), 32'(got_data.size()), 32'(n));
   endtask

   task automatic check_word(input string tag, input int idx, input logic [DWIDTH-1:0] d, input logic l);
      if (idx < got_data.size()) begin
         check($sformatf("%s data[%0d]", tag, idx), 32'(got_data[idx]), 32'(d));
         check($sformatf("%s last[%0d]", tag, idx), 32'(got_last[idx]), 32'(l));
      end
   endtask

   task automatic check_span(input string tag, input int n);
      if (got_cyc.size() >= n)
         check($sformatf("%s back-to-back span", tag), 32'(got_cyc[n-1] - got_cyc[0]), 32'(n - 1));
   endtask

   initial begin
      int k, p0;

      // Reset state
      srst_i = 1'b1; ready_i = 1'b0; flush_i = 1'b0;
      refresh();
      idle(2);
      check("reset data_o", 32'(data_o), 32'h0);
      check("reset valid_o", 32'(valid_o), 32'h0);
      check("reset last_o", 32'(last_o), 32'h0);
      check("reset busy_o", 32'(busy_o), 32'h0);
      check("reset rdreq", 32'(fifo_rdreq_o), 32'h0);
      srst_i = 1'b0;
      idle(2);
      check("idle busy_o", 32'(busy_o), 32'h0);

      // Full burst of 8 words 1..8
      ready_i = 1'b1;
      clear_log();
      for (int i = 1; i <= 8; i++) push(DWIDTH'(i));
      run_until(8, 40, 1'b0, "S1");
      for (int i = 0; i < 8; i++) check_word("S1", i, DWIDTH'(i + 1), i == 7);
      check_span("S1", 8);
      idle(3);
      check("S1 busy after", 32'(busy_o), 32'h0);

      // Partial burst forced by timeout
      clear_log();
      push(4'hA); push(4'hB); push(4'hC);
      p0 = pops; k = 0;
      while (pops == p0 && k < 40) begin step(); k++; end
      check("S2 first pop delay", 32'(k), 32'(TIMEOUT + 2));
      run_until(3, 20, 1'b0, "S2");
      check_word("S2", 0, 4'hA, 1'b0);
      check_word("S2", 1, 4'hB, 1'b0);
      check_word("S2", 2, 4'hC, 1'b1);
      idle(3);
      check("S2 tmo_cnt cleared", 32'(dut.tmo_cnt), 32'h0);
      check("S2 busy after", 32'(busy_o), 32'h0);

      // 20 words with ready toggling: 8 + 8 + 4 (timeout)
      clear_log();
      ready_i = 1'b0;
      for (int i = 1; i <= 20; i++) push(DWIDTH'(i));
      run_until(20, 200, 1'b1, "S3");
      for (int i = 0; i < 20; i++)
         check_word("S3", i, DWIDTH'(i + 1), (i == 7) || (i == 15) || (i == 19));
      check("S3 hold stability errors", 32'(stab_errs), 32'h0);
      ready_i = 1'b1;
      idle(3);

      // Flush forces an immediate burst of 5
      clear_log();
      push(4'h3); push(4'h5); push(4'h7); push(4'h9); push(4'hB);
      p0 = pops;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("S4 flush_pend set", 32'(dut.flush_pend), 32'h1);
      k = 1;
      while (pops == p0 && k < 20) begin step(); k++; end
      check("S4 first pop delay", 32'(k), 32'h3);
      run_until(5, 20, 1'b0, "S4");
      check_word("S4", 0, 4'h3, 1'b0);
      check_word("S4", 1, 4'h5, 1'b0);
      check_word("S4", 2, 4'h7, 1'b0);
      check_word("S4", 3, 4'h9, 1'b0);
      check_word("S4", 4, 4'hB, 1'b1);
      idle(3);
      check("S4 flush_pend cleared", 32'(dut.flush_pend), 32'h0);

      // Reset on the 3rd pop of an 8-word burst
      for (int i = 1; i <= 8; i++) push(DWIDTH'(i));
      p0 = pops; k = 0;
      while (pops < p0 + 2 && k < 20) begin step(); k++; end
      srst_i = 1'b1;
      #1;
      check("S5 rdreq during reset", 32'(fifo_rdreq_o), 32'h0);
      step();
      srst_i = 1'b0;
      clear_log();
      check("S5 valid after reset", 32'(valid_o), 32'h0);
      check("S5 last after reset", 32'(last_o), 32'h0);
      check("S5 busy after reset", 32'(busy_o), 32'h0);
      check("S5 rdreq after reset", 32'(fifo_rdreq_o), 32'h0);
      check("S5 fifo words left", 32'(fifo_mem.size()), 32'h6);
      p0 = pops;
      idle(5);
      check("S5 no pop without trigger", 32'(pops - p0), 32'h0);
      push(4'h9); push(4'hA);
      run_until(8, 40, 1'b0, "S5");
      for (int i = 0; i < 8; i++) check_word("S5", i, DWIDTH'(i + 3), i == 7);
      idle(3);

      // 16 words back-to-back: last on 8 and 16
      clear_log();
      for (int i = 0; i < 16; i++) push(DWIDTH'(i));
      run_until(16, 60, 1'b0, "S6");
      for (int i = 0; i < 16; i++) check_word("S6", i, DWIDTH'(i), (i == 7) || (i == 15));
      check_span("S6", 16);
      idle(3);
      check("pops while empty", 32'(bad_pops), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
